tt_stim_sig_harness: RTL and testbench
======================================

Name: tt_stim_sig_harness

Overview:
- Parametrised self-test harness for Tiny Tapeout user designs. It replaces a static wrapper that only wires up `ui_in`/`uo_out`.
- An LFSR generates stimulus vectors and drives them onto the DUT's input bus. After a programmable settle time it samples the DUT's output bus and compresses each sample into a MISR signature. At the end of a run it compares the signature against an expected value.
- Sits between the bench (or an on-chip bring-up controller) and the `tt_um_*` instance. Gives a single pass/fail per run.

Parameters:
- `IN_W`, 8, stimulus width (drives DUT `ui_in`).
- `OUT_W`, 8, DUT response width (from `uo_out`).
- `N_VEC`, 256, vectors per run; legal range 1..65535.
- `SETTLE`, 2, cycles a vector is held before sampling; minimum 1.
- `SEED`, 8'hA5, LFSR seed at run start; width `IN_W`; must be non-zero.
- `LFSR_TAPS`, 8'hB8, Galois LFSR tap mask; width `IN_W`.
- `MISR_TAPS`, 8'h1D, MISR feedback mask; width `OUT_W`.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous active-high reset.
- `start`, in, 1, single-cycle run request.
- `expected_sig`, in, `OUT_W`, golden signature; sampled in DONE.
- `dut_out`, in, `OUT_W`, DUT response bus.
- `stim_out`, out, `IN_W`, registered stimulus to DUT.
- `stim_valid`, out, 1, high while `stim_out` carries a run vector.
- `busy`, out, 1, run in progress.
- `done`, out, 1, run complete; level, held.
- `pass`, out, 1, signature match; valid only while `done` is high.
- `signature`, out, `OUT_W`, current MISR value.
- `vec_idx`, out, 16, index of the vector currently applied.

Behaviour:
- Reset (async, `rst` = 1) forces:
  - State IDLE.
  - Outputs: `stim_out` = 0, `stim_valid` = 0, `busy` = 0, `done` = 0, `pass` = 0, `signature` = 0, `vec_idx` = 0.
  - Internal LFSR = `SEED`, settle counter = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, on `start` = 1 at an edge:
  - Load LFSR = `SEED`, `signature` = 0, `vec_idx` = 0.
  - `stim_out` = `SEED`; `stim_valid` = 1, `busy` = 1.
  - Go to DRIVE with settle counter = 0.
- DRIVE:
  - Hold `stim_out`; increment the settle counter each cycle.
  - After `SETTLE` cycles in DRIVE, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - MISR update: `sig_next = (sig << 1) ^ (sig[OUT_W-1] ? MISR_TAPS : 0) ^ dut_out`. Shift truncates to `OUT_W`.
  - LFSR advance: `lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0)`.
  - If `vec_idx == N_VEC-1`: go to DONE, with `stim_valid` = 0, `busy` = 0, `stim_out` held at its last value.
  - Otherwise: `stim_out` = `lfsr_next`, `vec_idx`++, return to DRIVE.
- Per-vector cost is `SETTLE+1` cycles. If the start edge is E0, `done` rises after edge E0 + `N_VEC*(SETTLE+1)`.
- DONE:
  - `done` = 1.
  - `pass` = (`signature == expected_sig`), evaluated combinationally from the registered signature and the live `expected_sig`.
  - Both hold until reset or a new `start`.
  - `start` in DONE restarts exactly as from IDLE, and `done`/`pass` clear on that same edge.
- `start` while `busy` = 1 is ignored; the run is not restarted.
- Reset asserted mid-run aborts immediately to the reset values. No partial `done` is produced.
- `dut_out` is sampled only in SAMPLE; changes during DRIVE do not affect `signature`.
- `N_VEC` = 1 case: a single DRIVE/SAMPLE pass, then DONE.

Optional Feature:
- Macro: `TT_STIM_PAUSE_EN`.
- When defined:
  - Adds input port `pause` (1 bit).
  - While `pause` = 1 in DRIVE or SAMPLE, the state, settle counter, LFSR, MISR and `vec_idx` freeze, and `stim_out` holds. A SAMPLE cycle coinking with `pause` = 1 does not update the MISR.
  - `busy` stays 1 and `stim_valid` stays 1.
  - `pause` has no effect in IDLE or DONE.
- When undefined: no `pause` port; behaviour exactly as above.

Test Plan:
- Loopback check:
  - Setup: `IN_W` = `OUT_W` = 8, `N_VEC` = 4, `SETTLE` = 1, `dut_out` = `stim_out`; pulse `start`.
  - `stim_out` sequence A5, EA, 75, 82; `signature` after each SAMPLE A5, BD, 12, A6.
  - `done` = 1 after edge E0+8; `pass` = 1 with `expected_sig` = A6, `pass` = 0 with A7.
- Reset during DRIVE of vector 2 (same setup):
  - All outputs return to their reset values asynchronously, before the next clock edge.
  - A following `start` reproduces sequence A5, EA, 75, 82 and signature A6.
- Start while busy:
  - Pulse `start` again at cycle 3 of the run.
  - Sequence and `done` timing are unchanged (`done` at E0+8).
- Restart from DONE:
  - Hold DONE for 5 cycles, then pulse `start`.
  - `done`/`pass` clear on that edge; `stim_out` = A5; second run gives signature A6 again.
- Settle/sample isolation (`SETTLE` = 3, `dut_out` = `stim_out` except forced to FF during the DRIVE cycles only):
  - `signature` still A6 at `done`.
  - `done` at E0+16.
- With `TT_STIM_PAUSE_EN`:
  - Assert `pause` for 4 cycles during vector 1 (value EA).
  - `stim_out` stays EA and `vec_idx` stays 1; `done` slips to E0+12; signature still A6.

Source files
------------

// File: rtl/tt_stim_sig_harness.sv
// LFSR-stimulus / MISR-signature self-test harness for a Tiny Tapeout user design.
// Optional freeze input is built in when TT_STIM_PAUSE_EN is defined.
module tt_stim_sig_harness #(
   parameter int              IN_W      = 8,
   parameter int              OUT_W     = 8,
   parameter int              N_VEC     = 256,
   parameter int              SETTLE    = 2,
   parameter logic [IN_W-1:0]  SEED      = 8'hA5,
   parameter logic [IN_W-1:0]  LFSR_TAPS = 8'hB8,
   parameter logic [OUT_W-1:0] MISR_TAPS = 8'h1D
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef TT_STIM_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [OUT_W-1:0] expected_sig,
   input  logic [OUT_W-1:0] dut_out,
   output logic [IN_W-1:0]  stim_out,
   output logic             stim_valid,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [OUT_W-1:0] signature,
   output logic [15:0]      vec_idx
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [15:0] LAST_IDX    = 16'(N_VEC - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

   function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] l);
      return {1'b0, l[IN_W-1:1]} ^ (l[0] ? LFSR_TAPS : '0);
   endfunction

   function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                  input logic [OUT_W-1:0] d);
      return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? MISR_TAPS : '0) ^ d;
   endfunction

   state_t           state_r, state_n;
   logic [IN_W-1:0]  lfsr_r, lfsr_n;
   logic [IN_W-1:0]  stim_r, stim_n;
   logic [OUT_W-1:0] sig_r, sig_n;
   logic [15:0]      idx_r, idx_n;
   logic [15:0]      cnt_r, cnt_n;
   logic             valid_r, valid_n;
   logic             busy_r, busy_n;
   logic             done_r, done_n;
   logic             paused_s;

`ifdef TT_STIM_PAUSE_EN
   assign paused_s = pause;
`else
   assign paused_s = 1'b0;
`endif

   // Next-state and next-datapath decode for the run sequencer.
   always_comb begin
      state_n = state_r;
      lfsr_n  = lfsr_r;
      stim_n  = stim_r;
      sig_n   = sig_r;
      idx_n   = idx_r;
      cnt_n   = cnt_r;
      valid_n = valid_r;
      busy_n  = busy_r;
      done_n  = done_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_DRIVE;
               lfsr_n  = SEED;
               stim_n  = SEED;
               sig_n   = '0;
               idx_n   = 16'd0;
               cnt_n   = 16'd0;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               done_n  = 1'b0;
            end else begin
               state_n = state_r;
            end
         end
         S_DRIVE: begin
            if (paused_s) begin
               state_n = S_DRIVE;
            end else if (cnt_r == SETTLE_LAST) begin
               state_n = S_SAMPLE;
               cnt_n   = 16'd0;
            end else begin
               cnt_n = cnt_r + 16'd1;
            end
         end
         S_SAMPLE: begin
            if (paused_s) begin
               state_n = S_SAMPLE;
            end else begin
               sig_n  = misr_step(sig_r, dut_out);
               lfsr_n = lfsr_step(lfsr_r);
               if (idx_r == LAST_IDX) begin
                  state_n = S_DONE;
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_DRIVE;
                  stim_n  = lfsr_step(lfsr_r);
                  idx_n   = idx_r + 16'd1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         lfsr_r  <= SEED;
         stim_r  <= '0;
         sig_r   <= '0;
         idx_r   <= 16'd0;
         cnt_r   <= 16'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         lfsr_r  <= lfsr_n;
         stim_r  <= stim_n;
         sig_r   <= sig_n;
         idx_r   <= idx_n;
         cnt_r   <= cnt_n;
         valid_r <= valid_n;
         busy_r  <= busy_n;
         done_r  <= done_n;
      end
   end

   assign stim_out   = stim_r;
   assign stim_valid = valid_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign signature  = sig_r;
   assign vec_idx    = idx_r;
   // Live compare so a changed golden value is reflected without waiting a cycle.
   assign pass       = done_r && (sig_r == expected_sig);

endmodule

// File: tb/tb_tt_stim_sig_harness.sv
// Directed, table-driven bench for tt_stim_sig_harness (loopback, SETTLE=1 and SETTLE=3 instances).
module tb_tt_stim_sig_harness;

   typedef struct {
      logic [7:0] stim;
      logic [7:0] sig;
   } vec_t;

   vec_t tbl [4];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0;
   logic       start3 = 1'b0;
   logic [7:0] exp_sig = 8'hA6;
   logic [7:0] dut_out3 = 8'hFF;
   logic       sel = 1'b0;
`ifdef TT_STIM_PAUSE_EN
   logic       pause1 = 1'b0;
   logic       pause3 = 1'b0;
`endif

   logic [7:0]  stim1, stim3, sig1, sig3;
   logic [15:0] idx1, idx3;
   logic        valid1, valid3, busy1, busy3, done1, done3, pass1, pass3;

   logic [7:0]  m_stim, m_sig;
   logic [15:0] m_idx;
   logic        m_valid, m_busy, m_done, m_pass;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tt_stim_sig_harness #(.IN_W(8), .OUT_W(8), .N_VEC(4), .SETTLE(1),
      .SEED(8'hA5), .LFSR_TAPS(8'hB8), .MISR_TAPS(8'h1D)) u1 (
      .clk(clk), .rst(rst), .start(start1),
`ifdef TT_STIM_PAUSE_EN
      .pause(pause1),
`endif
      .expected_sig(exp_sig), .dut_out(stim1), .stim_out(stim1),
      .stim_valid(valid1), .busy(busy1), .done(done1), .pass(pass1),
      .signature(sig1), .vec_idx(idx1));

   tt_stim_sig_harness #(.IN_W(8), .OUT_W(8), .N_VEC(4), .SETTLE(3),
      .SEED(8'hA5), .LFSR_TAPS(8'hB8), .MISR_TAPS(8'h1D)) u3 (
      .clk(clk), .rst(rst), .start(start3),
`ifdef TT_STIM_PAUSE_EN
      .pause(pause3),
`endif
      .expected_sig(exp_sig), .dut_out(dut_out3), .stim_out(stim3),
      .stim_valid(valid3), .busy(busy3), .done(done3), .pass(pass3),
      .signature(sig3), .vec_idx(idx3));

   assign m_stim  = sel ? stim3  : stim1;
   assign m_sig   = sel ? sig3   : sig1;
   assign m_idx   = sel ? idx3   : idx1;
   assign m_valid = sel ? valid3 : valid1;
   assign m_busy  = sel ? busy3  : busy1;
   assign m_done  = sel ? done3  : done1;
   assign m_pass  = sel ? pass3  : pass1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " stim"},  16'(m_stim), 16'h0000);
      chk({tag, " valid"}, 16'(m_valid), 16'h0000);
      chk({tag, " busy"},  16'(m_busy), 16'h0000);
      chk({tag, " done"},  16'(m_done), 16'h0000);
      chk({tag, " pass"},  16'(m_pass), 16'h0000);
      chk({tag, " sig"},   16'(m_sig), 16'h0000);
      chk({tag, " idx"},   m_idx, 16'h0000);
   endtask

   task automatic set_start(input logic v);
      if (sel) start3 = v;
      else     start1 = v;
   endtask

   // Full 4-vector run; p = SETTLE+1, busy_rel >= 0 injects a start mid-run.
   task automatic run_check(input int p, input int busy_rel);
      @(negedge clk);
      set_start(1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(1'b0);
      for (int rel = 0; rel <= 4 * p; rel++) begin
         if (rel == 0) begin
            chk("start clears done", 16'(m_done), 16'h0000);
            chk("start clears pass", 16'(m_pass), 16'h0000);
         end
         if ((rel % p == 0) && (rel < 4 * p)) begin
            chk("stim", 16'(m_stim), 16'(tbl[rel / p].stim));
            chk("vec_idx", m_idx, 16'(rel / p));
            chk("stim_valid", 16'(m_valid), 16'h0001);
            chk("busy", 16'(m_busy), 16'h0001);
         end
         if ((rel % p == 0) && (rel > 0))
            chk("signature", 16'(m_sig), 16'(tbl[rel / p - 1].sig));
         if (rel == 4 * p - 1)
            chk("done early", 16'(m_done), 16'h0000);
         if (rel == 4 * p) begin
            chk("done", 16'(m_done), 16'h0001);
            chk("busy end", 16'(m_busy), 16'h0000);
            chk("valid end", 16'(m_valid), 16'h0000);
            chk("stim held", 16'(m_stim), 16'h0082);
            chk("pass A6", 16'(m_pass), 16'h0001);
            exp_sig = 8'hA7;
            #1;
            chk("pass A7", 16'(m_pass), 16'h0000);
            exp_sig = 8'hA6;
         end
         dut_out3 = ((rel % p == p - 1) && (rel < 4 * p)) ? tbl[rel / p].stim : 8'hFF;
         set_start(rel == busy_rel);
         if (rel < 4 * p) @(negedge clk);
      end
      set_start(1'b0);
   endtask

   initial begin
      tbl[0] = '{stim: 8'hA5, sig: 8'hA5};
      tbl[1] = '{stim: 8'hEA, sig: 8'hBD};
      tbl[2] = '{stim: 8'h75, sig: 8'h12};
      tbl[3] = '{stim: 8'h82, sig: 8'hA6};

      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // Basic loopback, then hold DONE and restart from it.
      run_check(2, -1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("done held", 16'(m_done), 16'h0001);
         chk("pass held", 16'(m_pass), 16'h0001);
      end
      run_check(2, -1);

      // Asynchronous reset during DRIVE of vector 2.
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-reset idx", m_idx, 16'h0002);
      rst = 1'b1;
      #1;
      chk_reset("async reset");
      @(negedge clk);
      rst = 1'b0;
      run_check(2, -1);

      // Start while busy is ignored.
      run_check(2, 3);

      // SETTLE=3 with FF on dut_out outside sample cycles.
      sel = 1'b1;
      run_check(4, -1);
      sel = 1'b0;

`ifdef TT_STIM_PAUSE_EN
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      pause1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("pause stim", 16'(m_stim), 16'h00EA);
         chk("pause idx", m_idx, 16'h0001);
         chk("pause busy", 16'(m_busy), 16'h0001);
         chk("pause valid", 16'(m_valid), 16'h0001);
      end
      pause1 = 1'b0;
      repeat (5) @(negedge clk);
      chk("pause done early", 16'(m_done), 16'h0000);
      @(negedge clk);
      chk("pause done", 16'(m_done), 16'h0001);
      chk("pause sig", 16'(m_sig), 16'h00A6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
